// File: rtl/i2c_cfg_pkg.sv
// Shared types and constants for the ES8388 configuration sequencer.
// Holds the table entry layout, register map and volume mapping.
package i2c_cfg_pkg;

    typedef enum logic {
        ENT_WRITE = 1'b0,
        ENT_WAIT  = 1'b1
    } ent_kind_t;

    typedef struct packed {
        ent_kind_t  kind;
        logic [7:0] addr;
        logic [7:0] data;
    } cfg_ent_t;

    localparam logic [7:0] R_CONTROL1  = 8'h00;
    localparam logic [7:0] R_CONTROL2  = 8'h01;
    localparam logic [7:0] R_CHIPPOWER = 8'h02;
    localparam logic [7:0] R_ADCPOWER  = 8'h03;
    localparam logic [7:0] R_DACPOWER  = 8'h04;
    localparam logic [7:0] R_ANAVOL    = 8'h07;
    localparam logic [7:0] R_MASTER    = 8'h08;
    localparam logic [7:0] R_ADCCTL1   = 8'h09;
    localparam logic [7:0] R_ADCCTL2   = 8'h0A;
    localparam logic [7:0] R_ADCCTL4   = 8'h0C;
    localparam logic [7:0] R_ADCCTL5   = 8'h0D;
    localparam logic [7:0] R_ADCCTL8   = 8'h10;
    localparam logic [7:0] R_ADCCTL9   = 8'h11;
    localparam logic [7:0] R_DACCTL1   = 8'h17;
    localparam logic [7:0] R_DACCTL2   = 8'h18;
    localparam logic [7:0] R_DACCTL3   = 8'h19;
    localparam logic [7:0] R_DACCTL4   = 8'h1A;
    localparam logic [7:0] R_DACCTL5   = 8'h1B;
    localparam logic [7:0] R_DACCTL6   = 8'h1C;
    localparam logic [7:0] R_DACCTL16  = 8'h26;
    localparam logic [7:0] R_DACCTL17  = 8'h27;
    localparam logic [7:0] R_DACCTL20  = 8'h2A;
    localparam logic [7:0] R_DACCTL21  = 8'h2B;
    localparam logic [7:0] R_DACCTL23  = 8'h2D;
    localparam logic [7:0] R_LOUT1VOL  = 8'h2E;
    localparam logic [7:0] R_ROUT1VOL  = 8'h2F;

    function automatic cfg_ent_t wr(input logic [7:0] a,
                                    input logic [7:0] d);
        return '{kind: ENT_WRITE, addr: a, data: d};
    endfunction

    // Two-bit selects use the fixed 15-dB-ish steps of the original
    // design; wider selects spread 0..60 linearly with rounding.
    function automatic logic [7:0] vol_map(input int unsigned v,
                                           input int unsigned w);
        int unsigned m;
        int unsigned r;
        if (w == 2)
            return 8'((v + 1) * 15);
        m = (1 << w) - 1;
        r = (v * 60 + m / 2) / m;
        if (r > 63)
            r = 63;
        return 8'(r);
    endfunction

endpackage

// File: rtl/es8388_cfg_rom.sv
// ES8388 init table: 24 writes, two output-volume defaults, DLL wait.
// Ports: idx (table index) in, ent (kind/addr/data) out, combinational.
module es8388_cfg_rom
    import i2c_cfg_pkg::*;
#(
    parameter int IDX_W = 5
) (
    input  logic [IDX_W-1:0] idx,
    output cfg_ent_t         ent
);

    always_comb begin
        ent = wr(8'h00, 8'h00);
        case (int'(idx))
            0:  ent = wr(R_CONTROL1,  8'h16);
            1:  ent = wr(R_CONTROL2,  8'h50);
            2:  ent = wr(R_CHIPPOWER, 8'h00);
            3:  ent = wr(R_ADCPOWER,  8'h00);
            4:  ent = wr(R_DACPOWER,  8'h3C);
            5:  ent = wr(R_MASTER,    8'h80);
            6:  ent = wr(R_ANAVOL,    8'h7C);
            7:  ent = wr(R_ADCCTL1,   8'h00);
            8:  ent = wr(R_ADCCTL2,   8'h00);
            9:  ent = wr(R_ADCCTL4,   8'h0C);
            10: ent = wr(R_ADCCTL5,   8'h02);
            11: ent = wr(R_ADCCTL8,   8'h00);
            12: ent = wr(R_ADCCTL9,   8'h00);
            13: ent = wr(R_DACCTL1,   8'h18);
            14: ent = wr(R_DACCTL2,   8'h02);
            15: ent = wr(R_DACCTL4,   8'h00);
            16: ent = wr(R_DACCTL5,   8'h00);
            17: ent = wr(R_DACCTL16,  8'h00);
            18: ent = wr(R_DACCTL17,  8'h90);
            19: ent = wr(R_DACCTL20,  8'h90);
            20: ent = wr(R_DACCTL21,  8'h80);
            21: ent = wr(R_DACCTL23,  8'h00);
            22: ent = wr(R_DACCTL3,   8'h02);
            23: ent = wr(R_DACCTL6,   8'h00);
            24: ent = wr(R_LOUT1VOL,  8'h1A);
            25: ent = wr(R_ROUT1VOL,  8'h1A);
            26: ent = '{kind: ENT_WAIT, addr: 8'h00, data: 8'h00};
            default: ent = wr(8'h00, 8'h00);
        endcase
    end

endmodule

// File: rtl/i2c_seq_cfg.sv
// Table-driven ES8388 register sequencer with retry and volume bursts.
// Ports: clk, rst, i2c_done/nack, volume in; exec/data, cfg_done/err, busy out.
module i2c_seq_cfg
    import i2c_cfg_pkg::*;
#(
    parameter int                ADDR_W    = 8,
    parameter int                DATA_W    = 8,
    parameter int                REG_NUM   = 27,
    parameter int                PWR_DLY   = 255,
    parameter int                WAIT_CYC  = 4096,
    parameter int                MAX_RETRY = 3,
    parameter int                VOL_W     = 2,
    parameter logic [ADDR_W-1:0] VOL_BASE  = 8'h2E
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i2c_done,
    input  logic                     i2c_nack,
    input  logic [VOL_W-1:0]         volume,
    output logic                     i2c_exec,
    output logic [ADDR_W+DATA_W-1:0] i2c_data,
    output logic                     cfg_done,
    output logic                     cfg_err,
    output logic                     busy
);

    localparam int IDX_W = $clog2(REG_NUM);
    localparam int MAXC  = (WAIT_CYC > PWR_DLY) ? WAIT_CYC : PWR_DLY;
    localparam int CNT_W = $clog2(MAXC) + 1;
    localparam int RTY_W = $clog2(MAX_RETRY + 1);
    localparam int DW    = ADDR_W + DATA_W;

    typedef enum logic [3:0] {
        PWR_WAIT, FETCH, ISSUE, WAIT_ACK, DELAY,
        DONE, VOL_ISSUE, VOL_WAIT, ERROR
    } state_t;

    state_t            state, state_nx;
    logic [IDX_W-1:0]  idx, idx_nx;
    logic [RTY_W-1:0]  retry, retry_nx;
    logic [CNT_W-1:0]  cnt, cnt_nx;
    logic [1:0]        vol_idx, vol_idx_nx;
    logic [VOL_W-1:0]  vol_q, vol_lvl, vol_lvl_nx;
    logic              pend, pend_nx;
    logic [DW-1:0]     data, data_nx;
    logic              done_q, err_q;
    logic              vol_chg, last, adv, dly_end;
    cfg_ent_t          ent;

    es8388_cfg_rom #(.IDX_W(IDX_W)) u_rom (
        .idx (idx),
        .ent (ent)
    );

    function automatic logic [DW-1:0] vol_word(input logic [1:0]       i,
                                               input logic [VOL_W-1:0] v);
        return {VOL_BASE + ADDR_W'(i), DATA_W'(vol_map(32'(v), VOL_W))};
    endfunction

    assign vol_chg = (volume != vol_q);
    assign last    = (idx == IDX_W'(REG_NUM - 1));
    assign dly_end = (cnt == CNT_W'(WAIT_CYC - 1));

    always_comb begin
        state_nx   = state;
        idx_nx     = idx;
        retry_nx   = retry;
        cnt_nx     = cnt;
        vol_idx_nx = vol_idx;
        vol_lvl_nx = vol_lvl;
        data_nx    = data;
        adv        = 1'b0;
        // Changes seen outside DONE are remembered for one later burst.
        pend_nx    = pend | (vol_chg & (state != DONE));
        unique case (state)
            PWR_WAIT: begin
                if (cnt == CNT_W'(PWR_DLY - 1)) begin
                    cnt_nx   = '0;
                    state_nx = FETCH;
                end else begin
                    cnt_nx = cnt + 1'b1;
                end
            end
            FETCH: begin
                if (ent.kind == ENT_WAIT) begin
                    state_nx = DELAY;
                end else begin
                    data_nx  = {ADDR_W'(ent.addr), DATA_W'(ent.data)};
                    state_nx = ISSUE;
                end
            end
            ISSUE:     state_nx = WAIT_ACK;
            VOL_ISSUE: state_nx = VOL_WAIT;
            WAIT_ACK, VOL_WAIT: begin
                if (i2c_done && !i2c_nack) begin
                    retry_nx = '0;
                    if (state == WAIT_ACK) begin
                        adv = 1'b1;
                    end else if (vol_idx == 2'd3) begin
                        state_nx = DONE;
                    end else begin
                        vol_idx_nx = vol_idx + 2'd1;
                        data_nx    = vol_word(vol_idx + 2'd1, vol_lvl);
                        state_nx   = VOL_ISSUE;
                    end
                end else if (i2c_done) begin
                    if (retry < RTY_W'(MAX_RETRY)) begin
                        retry_nx = retry + 1'b1;
                        state_nx = (state == WAIT_ACK) ? ISSUE : VOL_ISSUE;
                    end else begin
                        state_nx = ERROR;
                    end
                end
            end
            DELAY: begin
                if (dly_end) begin
                    cnt_nx = '0;
                    adv    = 1'b1;
                end else begin
                    cnt_nx = cnt + 1'b1;
                end
            end
            DONE: begin
                if (vol_chg || pend) begin
                    pend_nx    = 1'b0;
                    vol_idx_nx = 2'd0;
                    vol_lvl_nx = volume;
                    data_nx    = vol_word(2'd0, volume);
                    state_nx   = VOL_ISSUE;
                end
            end
            ERROR:   state_nx = ERROR;
            default: state_nx = PWR_WAIT;
        endcase
        // idx holds at the last entry so the table is never re-walked.
        if (adv) begin
            if (last) begin
                state_nx = DONE;
            end else begin
                idx_nx   = idx + 1'b1;
                state_nx = FETCH;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= PWR_WAIT;
            idx     <= '0;
            retry   <= '0;
            cnt     <= '0;
            vol_idx <= '0;
            vol_q   <= '0;
            vol_lvl <= '0;
            pend    <= 1'b0;
            data    <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state   <= state_nx;
            idx     <= idx_nx;
            retry   <= retry_nx;
            cnt     <= cnt_nx;
            vol_idx <= vol_idx_nx;
            vol_q   <= volume;
            vol_lvl <= vol_lvl_nx;
            pend    <= pend_nx;
            data    <= data_nx;
            done_q  <= done_q | (state_nx == DONE);
            err_q   <= err_q | (state_nx == ERROR);
        end
    end

    assign i2c_exec = (state == ISSUE) || (state == VOL_ISSUE);
    assign i2c_data = data;
    assign cfg_done = done_q;
    assign cfg_err  = err_q;
    assign busy     = (state == ISSUE) || (state == WAIT_ACK) ||
                      (state == DELAY) || (state == VOL_ISSUE) ||
                      (state == VOL_WAIT);

endmodule

// File: tb/tb_i2c_seq_cfg.sv
// Directed bench for i2c_seq_cfg with an I2C master model.
// The model answers each exec after three cycles and can NACK one word.
module tb_i2c_seq_cfg;

    localparam int PWR_DLY  = 255;
    localparam int WAIT_CYC = 4096;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        i2c_done = 1'b0;
    logic        i2c_nack = 1'b0;
    logic [1:0]  volume = 2'd0;
    logic        i2c_exec;
    logic [15:0] i2c_data;
    logic        cfg_done;
    logic        cfg_err;
    logic        busy;

    int n_vec = 0;
    int n_mis = 0;

    // master model state
    logic [15:0] log_q [0:63];
    int          n = 0;
    int          stab_err = 0;
    int          ncyc = 0;
    int          last_exec = 0;
    int          pend_cnt = 0;
    logic        pend_nack = 1'b0;
    logic [15:0] cur_data = '0;
    int          nack_used = 0;
    logic [15:0] nack_data = 16'hFFFF;
    int          nack_req = 0;

    i2c_seq_cfg dut (
        .clk      (clk),
        .rst      (rst),
        .i2c_done (i2c_done),
        .i2c_nack (i2c_nack),
        .volume   (volume),
        .i2c_exec (i2c_exec),
        .i2c_data (i2c_data),
        .cfg_done (cfg_done),
        .cfg_err  (cfg_err),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        ncyc++;
        if (rst) begin
            pend_cnt  = 0;
            i2c_done  = 1'b0;
            i2c_nack  = 1'b0;
            n         = 0;
            stab_err  = 0;
            nack_used = 0;
        end else begin
            if (pend_cnt > 0 && i2c_data != cur_data)
                stab_err++;
            i2c_done = 1'b0;
            i2c_nack = 1'b0;
            if (pend_cnt > 0) begin
                pend_cnt--;
                if (pend_cnt == 0) begin
                    i2c_done = 1'b1;
                    i2c_nack = pend_nack;
                end
            end
            if (i2c_exec) begin
                if (n < 64)
                    log_q[n] = i2c_data;
                n++;
                cur_data  = i2c_data;
                last_exec = ncyc;
                pend_cnt  = 3;
                pend_nack = (i2c_data == nack_data) &&
                            (nack_used < nack_req);
                if (pend_nack)
                    nack_used++;
            end
        end
    end

    task automatic chk(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h, want %0h", tag, obs, exp);
        end
    endtask

    function automatic int count_of(input logic [15:0] d);
        int c = 0;
        for (int i = 0; i < n && i < 64; i++)
            if (log_q[i] == d)
                c++;
        return c;
    endfunction

    task automatic do_reset(input logic [15:0] nd, input int nr);
        @(negedge clk);
        rst = 1'b1;
        volume = 2'd0;
        nack_data = nd;
        nack_req = nr;
        repeat (3) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic wait_done(input int lim);
        for (int i = 0; i < lim && !cfg_done; i++)
            @(negedge clk);
    endtask

    task automatic wait_n(input int target, input int lim);
        for (int i = 0; i < lim && n < target; i++)
            @(negedge clk);
    endtask

    initial begin
        int k;
        int gap;

        // reset state
        repeat (3) @(negedge clk);
        chk("rst_exec", i2c_exec, 0);
        chk("rst_data", i2c_data, 0);
        chk("rst_done", cfg_done, 0);
        chk("rst_err",  cfg_err,  0);
        chk("rst_busy", busy,     0);

        // power-up delay: cycle 0 is the period after the first rst-low edge
        rst = 1'b0;
        k = 0;
        for (int i = 0; i < 1000 && !i2c_exec; i++) begin
            @(negedge clk);
            k++;
        end
        chk("t1_lat", k - 1, PWR_DLY);
        chk("t1_first", i2c_data, 16'h0016);

        k = 0;
        for (int i = 0; i < 20000 && !cfg_done; i++) begin
            @(negedge clk);
            k = i;
        end
        gap = ncyc - last_exec;
        chk("t1_done", cfg_done, 1);
        chk("t1_nwr", n, 26);
        chk("t1_e5", log_q[5], 16'h0880);
        chk("t1_e24", log_q[24], 16'h2E1A);
        chk("t1_e25", log_q[25], 16'h2F1A);
        chk("t1_gap", (gap >= WAIT_CYC && gap <= WAIT_CYC + 8), 1);
        chk("t1_stab", stab_err, 0);
        chk("t1_err", cfg_err, 0);
        chk("t1_busy", busy, 0);

        // volume 00 -> 11 after configuration
        volume = 2'd3;
        wait_n(30, 200);
        repeat (100) @(negedge clk);
        chk("t4_n", n, 30);
        chk("t4_w0", log_q[26], 16'h2E3C);
        chk("t4_w1", log_q[27], 16'h2F3C);
        chk("t4_w2", log_q[28], 16'h303C);
        chk("t4_w3", log_q[29], 16'h313C);
        chk("t4_busy", busy, 0);
        chk("t4_done", cfg_done, 1);

        // changes during a burst coalesce into one more burst
        volume = 2'd1;
        wait_n(31, 200);
        repeat (2) @(negedge clk);
        volume = 2'd2;
        repeat (3) @(negedge clk);
        volume = 2'd3;
        repeat (300) @(negedge clk);
        chk("t5_n", n, 38);
        chk("t5_a0", log_q[30], 16'h2E1E);
        chk("t5_a3", log_q[33], 16'h311E);
        chk("t5_b0", log_q[34], 16'h2E3C);
        chk("t5_b3", log_q[37], 16'h313C);
        chk("t5_stab", stab_err, 0);

        // entry 5 NACKed twice, then ACKed
        do_reset(16'h0880, 2);
        wait_done(20000);
        chk("t2_done", cfg_done, 1);
        chk("t2_err", cfg_err, 0);
        chk("t2_n", n, 28);
        chk("t2_cnt", count_of(16'h0880), 3);
        chk("t2_next", log_q[8], 16'h077C);

        // entry 3 NACKed every time: budget runs out
        do_reset(16'h0300, 10);
        for (int i = 0; i < 3000 && !cfg_err; i++)
            @(negedge clk);
        repeat (100) @(negedge clk);
        chk("t3_err", cfg_err, 1);
        chk("t3_busy", busy, 0);
        chk("t3_done", cfg_done, 0);
        chk("t3_n", n, 7);
        chk("t3_cnt", count_of(16'h0300), 4);

        // reset in the middle of the write to entry 10
        do_reset(16'hFFFF, 0);
        wait_n(11, 2000);
        chk("t6_e10", log_q[10], 16'h0D02);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("t6_exec", i2c_exec, 0);
        chk("t6_data", i2c_data, 0);
        chk("t6_busy", busy, 0);
        @(negedge clk);
        rst = 1'b0;
        wait_n(1, 1000);
        chk("t6_first", log_q[0], 16'h0016);
        wait_done(20000);
        chk("t6_done", cfg_done, 1);
        chk("t6_n", n, 26);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule
